// File: rtl/cpu_types_pkg.sv
// Shared CPU types: the 32-bit word and the instruction-cache frame layout.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    localparam int ITAG_W  = 26;
    localparam int IIDX_W  = 4;
    localparam int IFRAMES = 16;

    typedef struct packed {
        logic              valid;
        logic [ITAG_W-1:0] tag;
        word_t             data;
    } icache_frame_t;

endpackage

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache: 16 one-word frames, zero-cycle
// hits, and a single blocking fill from memory control on every miss.
module icache
    import cpu_types_pkg::*;
(
    input  logic  CLK,
    input  logic  nRST,
    input  logic  imemREN,
    input  word_t imemaddr,
    output logic  ihit,
    output word_t imemload,
    input  logic  iflush,
    output logic  iREN,
    output word_t iaddr,
    input  logic  iwait,
    input  word_t iload
);

    typedef enum logic {IDLE, FETCH} icache_state_t;

    icache_state_t     state, state_nxt;
    icache_frame_t     frames [IFRAMES];
    logic [29:0]       fill_addr;
    logic              flush_pend;

    logic [IIDX_W-1:0] idx;
    logic [ITAG_W-1:0] tag;
    logic [IIDX_W-1:0] fill_idx;
    logic [ITAG_W-1:0] fill_tag;
    logic              hit;
    logic              start_fill;
    logic              fill_done;
    logic              unused_offset;

    // Byte offset never selects anything: misaligned fetches read the whole word.
    assign unused_offset = ^imemaddr[1:0];

    // Lookup, memory-side request and next-state decision.
    always_comb begin
        idx        = imemaddr[5:2];
        tag        = imemaddr[31:6];
        fill_idx   = fill_addr[IIDX_W-1:0];
        fill_tag   = fill_addr[29:4];
        hit        = 1'b0;
        start_fill = 1'b0;
        fill_done  = 1'b0;
        state_nxt  = state;
        ihit       = 1'b0;
        imemload   = '0;
        iREN       = 1'b0;
        iaddr      = '0;

        case (state)
            IDLE: begin
                hit = imemREN && !iflush && frames[idx].valid && (frames[idx].tag == tag);
                if (imemREN && !iflush && !hit) begin
                    start_fill = 1'b1;
                    state_nxt  = FETCH;
                end
            end
            FETCH: begin
                iREN  = 1'b1;
                iaddr = {fill_addr, 2'b00};
                if (!iwait) begin
                    fill_done = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        ihit     = hit;
        imemload = hit ? frames[idx].data : '0;
    end

    // State, fill address and deferred-flush flag.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            fill_addr  <= '0;
            flush_pend <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start_fill)
                fill_addr <= imemaddr[31:2];
            // A flush seen during a fill is held until the fill lands.
            if (fill_done)
                flush_pend <= 1'b0;
            else if (state == FETCH && iflush)
                flush_pend <= 1'b1;
        end
    end

    // Frame array: fill on the completing edge, flushes clear every valid bit.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < IFRAMES; i++)
                frames[i] <= '0;
        end else if (fill_done) begin
            frames[fill_idx] <= '{valid: !(flush_pend || iflush), tag: fill_tag, data: iload};
            if (flush_pend || iflush) begin
                for (int i = 0; i < IFRAMES; i++)
                    if (i != int'(fill_idx))
                        frames[i].valid <= 1'b0;
            end
        end else if (state == IDLE && iflush) begin
            for (int i = 0; i < IFRAMES; i++)
                frames[i].valid <= 1'b0;
        end
    end

endmodule
